// File: rtl/toy_mem_adapter_pipe.sv
// Request/ack bus to synchronous SRAM port with fixed read latency.
// A tag pipeline tracks issued accesses; a credit-counted ack FIFO absorbs ack backpressure.
module toy_mem_adapter_pipe #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int RD_LAT    = 1,
  parameter int ACK_DEPTH = 4,
  localparam int BE_W     = DATA_W / 8,
  localparam int OFS      = $clog2(BE_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_req_vld,
  output logic                  in0_req_rdy,
  input  logic [ADDR_W-1:0]     in0_req_addr,
  input  logic [BE_W-1:0]       in0_req_strb,
  input  logic [DATA_W-1:0]     in0_req_data,
  input  logic                  in0_req_opcode,
  input  logic [ID_W-1:0]       in0_req_src_id,
  input  logic [ID_W-1:0]       in0_req_tgt_id,
  output logic                  in0_ack_vld,
  input  logic                  in0_ack_rdy,
  output logic                  in0_ack_opcode,
  output logic [DATA_W-1:0]     in0_ack_data,
  output logic [ID_W-1:0]       in0_ack_src_id,
  output logic [ID_W-1:0]       in0_ack_tgt_id,
  output logic                  out0_mem_en,
  output logic [ADDR_W-OFS-1:0] out0_mem_addr,
  input  logic [DATA_W-1:0]     out0_mem_rd_data,
  output logic [DATA_W-1:0]     out0_mem_wr_data,
  output logic [BE_W-1:0]       out0_mem_wr_byte_en,
  output logic                  out0_mem_wr_en
);
  localparam int PW = $clog2(ACK_DEPTH);
  localparam logic [PW:0] DEPTH_C = ACK_DEPTH[PW:0];

  logic            acc, push, pop, full, empty;
  logic [PW:0]     cnt, wr_ptr, rd_ptr;
  logic [PW-1:0]   wr_idx, rd_idx;
  logic [RD_LAT-1:0] p_vld, p_op;
  logic [ID_W-1:0] p_src [RD_LAT];
  logic [ID_W-1:0] p_tgt [RD_LAT];
  logic              f_op   [ACK_DEPTH];
  logic [DATA_W-1:0] f_data [ACK_DEPTH];
  logic [ID_W-1:0]   f_src  [ACK_DEPTH];
  logic [ID_W-1:0]   f_tgt  [ACK_DEPTH];
  logic            unused_addr_bits;

  // Ready looks only at registered credit state, never at in0_ack_rdy.
  assign in0_req_rdy = !rst && (cnt < DEPTH_C);
  assign acc         = in0_req_vld && in0_req_rdy;

  assign out0_mem_en         = acc;
  assign out0_mem_wr_en      = acc && in0_req_opcode;
  assign out0_mem_addr       = in0_req_addr[ADDR_W-1:OFS];
  assign out0_mem_wr_data    = in0_req_data;
  assign out0_mem_wr_byte_en = in0_req_strb;
  assign unused_addr_bits    = ^in0_req_addr[OFS-1:0];

  assign wr_idx = wr_ptr[PW-1:0];
  assign rd_idx = rd_ptr[PW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
  assign push   = p_vld[RD_LAT-1];
  assign pop    = in0_ack_vld && in0_ack_rdy;

  assign in0_ack_vld    = !empty;
  assign in0_ack_opcode = !empty && f_op[rd_idx];
  assign in0_ack_data   = empty ? '0 : f_data[rd_idx];
  assign in0_ack_src_id = empty ? '0 : f_src[rd_idx];
  assign in0_ack_tgt_id = empty ? '0 : f_tgt[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld <= '0;
    end else begin
      p_vld[0] <= acc;
      for (int i = 1; i < RD_LAT; i++) p_vld[i] <= p_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    p_op[0]  <= in0_req_opcode;
    p_src[0] <= in0_req_src_id;
    p_tgt[0] <= in0_req_tgt_id;
    for (int i = 1; i < RD_LAT; i++) begin
      p_op[i]  <= p_op[i-1];
      p_src[i] <= p_src[i-1];
      p_tgt[i] <= p_tgt[i-1];
    end
  end

  // Last tag stage lines up with read data, so the push captures it directly.
  always_ff @(posedge clk) begin
    if (push) begin
      f_op[wr_idx]   <= p_op[RD_LAT-1];
      f_data[wr_idx] <= p_op[RD_LAT-1] ? '0 : out0_mem_rd_data;
      f_src[wr_idx]  <= p_tgt[RD_LAT-1];
      f_tgt[wr_idx]  <= p_src[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({acc, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_toy_mem_adapter_pipe.sv
// Directed bench: instance A uses default parameters, instance B uses RD_LAT=2.
// Each memory model is a behavioural SRAM that returns read data RD_LAT cycles after enable.
module tb_toy_mem_adapter_pipe;
  logic clk, rst, load;
  int total, bad;

  logic        a_req_vld, a_req_rdy, a_req_opcode, a_ack_vld, a_ack_rdy, a_ack_opcode;
  logic [31:0] a_req_addr, a_req_data, a_ack_data, a_rd_q, a_mem_wr_data;
  logic [3:0]  a_req_strb, a_req_src, a_req_tgt, a_ack_src, a_ack_tgt, a_mem_be;
  logic        a_mem_en, a_mem_wr_en;
  logic [29:0] a_mem_addr;
  logic [31:0] mem_a [0:255];

  logic        b_req_vld, b_req_rdy, b_req_opcode, b_ack_vld, b_ack_rdy, b_ack_opcode;
  logic [31:0] b_req_addr, b_req_data, b_ack_data, b_rd_q1, b_rd_q2, b_mem_wr_data;
  logic [3:0]  b_req_strb, b_req_src, b_req_tgt, b_ack_src, b_ack_tgt, b_mem_be;
  logic        b_mem_en, b_mem_wr_en;
  logic [29:0] b_mem_addr;

  toy_mem_adapter_pipe dut_a (
    .clk(clk), .rst(rst),
    .in0_req_vld(a_req_vld), .in0_req_rdy(a_req_rdy), .in0_req_addr(a_req_addr),
    .in0_req_strb(a_req_strb), .in0_req_data(a_req_data), .in0_req_opcode(a_req_opcode),
    .in0_req_src_id(a_req_src), .in0_req_tgt_id(a_req_tgt),
    .in0_ack_vld(a_ack_vld), .in0_ack_rdy(a_ack_rdy), .in0_ack_opcode(a_ack_opcode),
    .in0_ack_data(a_ack_data), .in0_ack_src_id(a_ack_src), .in0_ack_tgt_id(a_ack_tgt),
    .out0_mem_en(a_mem_en), .out0_mem_addr(a_mem_addr), .out0_mem_rd_data(a_rd_q),
    .out0_mem_wr_data(a_mem_wr_data), .out0_mem_wr_byte_en(a_mem_be), .out0_mem_wr_en(a_mem_wr_en)
  );

  toy_mem_adapter_pipe #(.RD_LAT(2), .ACK_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .in0_req_vld(b_req_vld), .in0_req_rdy(b_req_rdy), .in0_req_addr(b_req_addr),
    .in0_req_strb(b_req_strb), .in0_req_data(b_req_data), .in0_req_opcode(b_req_opcode),
    .in0_req_src_id(b_req_src), .in0_req_tgt_id(b_req_tgt),
    .in0_ack_vld(b_ack_vld), .in0_ack_rdy(b_ack_rdy), .in0_ack_opcode(b_ack_opcode),
    .in0_ack_data(b_ack_data), .in0_ack_src_id(b_ack_src), .in0_ack_tgt_id(b_ack_tgt),
    .out0_mem_en(b_mem_en), .out0_mem_addr(b_mem_addr), .out0_mem_rd_data(b_rd_q2),
    .out0_mem_wr_data(b_mem_wr_data), .out0_mem_wr_byte_en(b_mem_be), .out0_mem_wr_en(b_mem_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: preloaded word i = A000_0000+i, word 4 = DEADBEEF, word 8 = FFFFFFFF.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA000_0000 + i;
      mem_a[4] <= 32'hDEAD_BEEF;
      mem_a[8] <= 32'hFFFF_FFFF;
    end else if (a_mem_en) begin
      if (a_mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (a_mem_be[b]) mem_a[a_mem_addr[7:0]][8*b +: 8] <= a_mem_wr_data[8*b +: 8];
      end else begin
        a_rd_q <= mem_a[a_mem_addr[7:0]];
      end
    end
  end

  // Memory B: read-only, word w returns B000_0000|w two cycles after enable.
  always @(posedge clk) begin
    b_rd_q1 <= b_mem_en ? (32'hB000_0000 | {24'h0, b_mem_addr[7:0]}) : 32'h0;
    b_rd_q2 <= b_rd_q1;
  end

  task automatic drive_a(input logic vld, input logic op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic [3:0] src, input logic [3:0] tgt);
    a_req_vld = vld; a_req_opcode = op; a_req_addr = addr; a_req_data = data;
    a_req_strb = strb; a_req_src = src; a_req_tgt = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1;
    drive_a(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 4'h0, 4'h0);
    a_ack_rdy = 1'b1;
    b_req_vld = 1'b0; b_ack_rdy = 1'b0; b_req_opcode = 1'b0; b_req_addr = '0;
    b_req_data = '0; b_req_strb = '0; b_req_src = '0; b_req_tgt = '0;
    repeat (3) @(negedge clk);
    total++; if (a_req_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got %b want 0", a_req_rdy); end
    total++; if (a_mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got %b want 0", a_mem_en); end
    total++; if (a_mem_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b want 0", a_mem_wr_en); end
    total++; if (a_ack_vld !== 1'b0) begin bad++; $display("FAIL reset_ack_vld got %b want 0", a_ack_vld); end
    total++; if ({a_ack_opcode, a_ack_data, a_ack_src, a_ack_tgt} !== 41'h0) begin bad++; $display("FAIL reset_ack_payload got %h want 0", a_ack_data); end
    total++; if (b_req_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy_b got %b want 0", b_req_rdy); end
    rst = 1'b0; load = 1'b0;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    #1;
    total++; if (a_req_rdy !== 1'b1) begin bad++; $display("FAIL release_rdy got %b want 1", a_req_rdy); end
    total++; if (b_req_rdy !== 1'b1) begin bad++; $display("FAIL release_rdy_b got %b want 1", b_req_rdy); end
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    a_ack_rdy = 1'b1;
    drive_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'd3, 4'd5);
    #1;
    total++; if (a_mem_en !== 1'b1 || a_mem_wr_en !== 1'b0) begin bad++; $display("FAIL rd_strobe got en=%b wr=%b want 1/0", a_mem_en, a_mem_wr_en); end
    total++; if (a_mem_addr !== 30'h4) begin bad++; $display("FAIL rd_addr got %h want 4", a_mem_addr); end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    #1;
    total++; if (a_ack_vld !== 1'b0) begin bad++; $display("FAIL rd_early_ack got %b want 0", a_ack_vld); end
    @(negedge clk); #1;
    total++; if (a_ack_vld !== 1'b1) begin bad++; $display("FAIL rd_ack_vld got %b want 1", a_ack_vld); end
    total++; if (a_ack_opcode !== 1'b0) begin bad++; $display("FAIL rd_ack_op got %b want 0", a_ack_opcode); end
    total++; if (a_ack_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_ack_data got %h want deadbeef", a_ack_data); end
    total++; if (a_ack_src !== 4'd5 || a_ack_tgt !== 4'd3) begin bad++; $display("FAIL rd_ack_ids got %0d/%0d want 5/3", a_ack_src, a_ack_tgt); end
    @(negedge clk); #1;
    total++; if (a_ack_vld !== 1'b0) begin bad++; $display("FAIL rd_ack_popped got %b want 0", a_ack_vld); end
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    drive_a(1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 4'd1, 4'd2);
    #1;
    total++; if (a_mem_wr_en !== 1'b1) begin bad++; $display("FAIL wr_en got %b want 1", a_mem_wr_en); end
    total++; if (a_mem_be !== 4'b0101 || a_mem_wr_data !== 32'h1122_3344 || a_mem_addr !== 30'h8) begin bad++; $display("FAIL wr_pass got be=%b d=%h a=%h want 0101/11223344/8", a_mem_be, a_mem_wr_data, a_mem_addr); end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    #1;
    total++; if (a_ack_vld !== 1'b0) begin bad++; $display("FAIL wr_early_ack got %b want 0", a_ack_vld); end
    @(negedge clk); #1;
    total++; if (a_ack_vld !== 1'b1 || a_ack_opcode !== 1'b1) begin bad++; $display("FAIL wr_ack got vld=%b op=%b want 1/1", a_ack_vld, a_ack_opcode); end
    total++; if (a_ack_data !== 32'h0) begin bad++; $display("FAIL wr_ack_data got %h want 0", a_ack_data); end
    total++; if (a_ack_src !== 4'd2 || a_ack_tgt !== 4'd1) begin bad++; $display("FAIL wr_ack_ids got %0d/%0d want 2/1", a_ack_src, a_ack_tgt); end
    @(negedge clk);
    drive_a(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 4'd6, 4'd7);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk); #1;
    total++; if (a_ack_vld !== 1'b1 || a_ack_data !== 32'hFF22_FF44) begin bad++; $display("FAIL wr_readback got vld=%b d=%h want 1/ff22ff44", a_ack_vld, a_ack_data); end
  endtask

  task automatic test_streaming();
    logic        exp_op [64];
    logic [31:0] exp_data [64];
    int          stalls, acks, cnt_hi, ack_bad;
    stalls = 0; acks = 0; cnt_hi = 0; ack_bad = 0;
    a_ack_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp_op[i]   = (i % 3 == 0);
      exp_data[i] = exp_op[i] ? 32'h0 : 32'hA000_0020 + (i % 16);
    end
    for (int c = 0; c < 66; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        acks++;
        if (a_ack_vld !== 1'b1 || a_ack_opcode !== exp_op[c-2] || a_ack_data !== exp_data[c-2] ||
            a_ack_src !== ~4'(c-2) || a_ack_tgt !== 4'(c-2)) begin
          ack_bad++;
          $display("FAIL stream_ack%0d got vld=%b op=%b d=%h want 1/%b/%h", c-2, a_ack_vld, a_ack_opcode, a_ack_data, exp_op[c-2], exp_data[c-2]);
        end
      end
      if (c < 64) begin
        if (a_req_rdy !== 1'b1) stalls++;
        if (dut_a.cnt > 3'd2) cnt_hi++;
        drive_a(1'b1, exp_op[c], exp_op[c] ? 32'h100 + 4*(c % 16) : 32'h80 + 4*(c % 16),
                32'h0101_0101 * c, 4'hF, 4'(c), ~4'(c));
      end else begin
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
      end
    end
    total++; if (ack_bad != 0 || acks != 64) begin bad++; $display("FAIL stream_acks got bad=%0d n=%0d want 0/64", ack_bad, acks); end
    total++; if (stalls != 0) begin bad++; $display("FAIL stream_stalls got %0d want 0", stalls); end
    total++; if (cnt_hi != 0) begin bad++; $display("FAIL stream_cnt_max got %0d over-2 cycles want 0", cnt_hi); end
    @(negedge clk); #1;
    total++; if (a_ack_vld !== 1'b0 || dut_a.cnt !== 3'd0) begin bad++; $display("FAIL stream_drained got vld=%b cnt=%0d want 0/0", a_ack_vld, dut_a.cnt); end
  endtask

  task automatic test_simul_accept_pop();
    a_ack_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b0, 32'(4*(40+k)), 32'h0, 4'h0, 4'(k), 4'(8+k));
    end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (dut_a.cnt !== 3'd3 || a_ack_vld !== 1'b1 || a_ack_data !== 32'hA000_0028) begin bad++; $display("FAIL sim_queued got cnt=%0d vld=%b d=%h want 3/1/a0000028", dut_a.cnt, a_ack_vld, a_ack_data); end
    @(negedge clk);
    drive_a(1'b1, 1'b0, 32'(4*43), 32'h0, 4'h0, 4'd3, 4'd11);
    a_ack_rdy = 1'b1;
    #1;
    total++; if (a_req_rdy !== 1'b1 || a_mem_en !== 1'b1) begin bad++; $display("FAIL sim_accept got rdy=%b en=%b want 1/1", a_req_rdy, a_mem_en); end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    a_ack_rdy = 1'b0;
    #1;
    total++; if (dut_a.cnt !== 3'd3 || a_req_rdy !== 1'b1) begin bad++; $display("FAIL sim_cnt got cnt=%0d rdy=%b want 3/1", dut_a.cnt, a_req_rdy); end
    total++; if (a_ack_data !== 32'hA000_0029 || a_ack_src !== 4'd9) begin bad++; $display("FAIL sim_head got d=%h src=%0d want a0000029/9", a_ack_data, a_ack_src); end
    @(negedge clk);
    a_ack_rdy = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    total++; if (dut_a.cnt !== 3'd0 || a_ack_vld !== 1'b0) begin bad++; $display("FAIL sim_drain got cnt=%0d vld=%b want 0/0", dut_a.cnt, a_ack_vld); end
  endtask

  task automatic test_backpressure();
    int sent, got, acc_bp, ord_bad;
    sent = 0; got = 0; ord_bad = 0;
    b_ack_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b_req_vld = (sent < 8); b_req_opcode = 1'b0; b_req_addr = 32'(4*sent);
      b_req_src = 4'(sent); b_req_tgt = 4'(15 - sent);
      #1;
      if (b_req_vld && b_req_rdy) sent++;
    end
    acc_bp = sent;
    total++; if (acc_bp != 4) begin bad++; $display("FAIL bp_accepted got %0d want 4", acc_bp); end
    total++; if (b_req_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_low got %b want 0", b_req_rdy); end
    total++; if (b_ack_vld !== 1'b1 || b_ack_data !== 32'hB000_0000) begin bad++; $display("FAIL bp_head got vld=%b d=%h want 1/b0000000", b_ack_vld, b_ack_data); end
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      b_ack_rdy = 1'b1;
      b_req_vld = (sent < 8); b_req_addr = 32'(4*sent);
      b_req_src = 4'(sent); b_req_tgt = 4'(15 - sent);
      #1;
      if (c == 1) begin
        total++; if (b_req_rdy !== 1'b1) begin bad++; $display("FAIL bp_rerise got %b want 1", b_req_rdy); end
      end
      if (b_ack_vld) begin
        if (b_ack_data !== (32'hB000_0000 | got) || b_ack_src !== 4'(15 - got) || b_ack_tgt !== 4'(got)) begin
          ord_bad++;
          $display("FAIL bp_ack%0d got d=%h src=%0d want %h/%0d", got, b_ack_data, b_ack_src, 32'hB000_0000 | got, 15 - got);
        end
        got++;
      end
      if (b_req_vld && b_req_rdy) sent++;
    end
    b_req_vld = 1'b0;
    total++; if (got != 8 || ord_bad != 0) begin bad++; $display("FAIL bp_order got n=%0d bad=%0d want 8/0", got, ord_bad); end
  endtask

  task automatic test_reset_mid();
    a_ack_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b0, 32'(4*(44+k)), 32'h0, 4'h0, 4'(k), 4'(k));
    end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    drive_a(1'b1, 1'b0, 32'(4*47), 32'h0, 4'h0, 4'd3, 4'd3);
    #1;
    total++; if (a_ack_vld !== 1'b1 || dut_a.cnt !== 3'd3 || a_req_rdy !== 1'b1) begin bad++; $display("FAIL rm_setup got vld=%b cnt=%0d rdy=%b want 1/3/1", a_ack_vld, dut_a.cnt, a_req_rdy); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (a_ack_vld !== 1'b0 || a_req_rdy !== 1'b0 || a_mem_en !== 1'b0) begin bad++; $display("FAIL rm_async got vld=%b rdy=%b en=%b want 0/0/0", a_ack_vld, a_req_rdy, a_mem_en); end
    @(negedge clk);
    rst = 1'b0; a_ack_rdy = 1'b1;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if (a_ack_vld !== 1'b0) begin bad++; $display("FAIL rm_no_ack%0d got %b want 0", c, a_ack_vld); end
    end
    @(negedge clk);
    drive_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'd7, 4'd9);
    #1;
    total++; if (a_req_rdy !== 1'b1) begin bad++; $display("FAIL rm_rdy got %b want 1", a_req_rdy); end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    #1;
    total++; if (a_ack_vld !== 1'b0) begin bad++; $display("FAIL rm_early got %b want 0", a_ack_vld); end
    @(negedge clk); #1;
    total++; if (a_ack_vld !== 1'b1 || a_ack_data !== 32'hDEAD_BEEF || a_ack_src !== 4'd9 || a_ack_tgt !== 4'd7) begin bad++; $display("FAIL rm_ack got vld=%b d=%h src=%0d want 1/deadbeef/9", a_ack_vld, a_ack_data, a_ack_src); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_read_latency();
    test_byte_write();
    test_streaming();
    test_simul_accept_pop();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
